result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Synthesizable end-of-test checker that sits beside the CPU data memory and consumes what the program writes there.
- Snoops the DM write port for the done-flag store: byte 0xff to byte address 0xfffc.
- On that store, walks the answer region word by word through a DM read port and compares each word against a golden ROM.
- Reports error count, per-mismatch records and pass/fail. Also flags a cycle-budget timeout.

Parameters:
- AW, 16, DM byte-address width
- ANSWER_START, 16'h9000, byte address of answer word 0
- DONE_ADDR, 16'hfffc, word-aligned byte address of the done flag (flag is byte lane 0)
- DONE_BYTE, 8'hff, done-flag value
- GOLD_DEPTH, 100, golden ROM entries
- GW, 7, golden address width
- MAX_CYCLES, 50000, cycle budget counted from reset release
- CW, 16, cycle counter width

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- dm_web, input, 4, DM byte write enables, active high, bit n = byte lane n
- dm_addr, input, AW, DM word-aligned byte address
- dm_di, input, 32, DM write data
- num_words, input, 8, golden word count, sampled at the done store
- rd_req, output, 1, DM read strobe
- rd_addr, output, AW, DM read byte address
- rd_data, input, 32, DM read data, valid 1 cycle after rd_req
- gold_addr, output, GW, golden ROM index
- gold_data, input, 32, golden word, valid 1 cycle after gold_addr is presented
- fail_valid, output, 1, 1-cycle pulse per mismatch
- fail_idx, output, GW, index of the mismatching word
- fail_data, output, 32, DM value of the mismatching word
- fail_expect, output, 32, golden value of the mismatching word
- err_cnt, output, 8, mismatch count, saturates at 255
- done, output, 1, compare complete, sticky
- pass, output, 1, done && err_cnt==0, sticky
- timeout, output, 1, budget exhausted before the done store, sticky

Behaviour:
- Reset, synchronous, any state:
  - FSM returns to RUN.
  - Cycle counter, word index and err_cnt = 0.
  - All outputs = 0: rd_req, rd_addr, gold_addr, fail_*, done, pass, timeout.
  - Reset mid-compare abandons the walk completely.
- States: RUN, SETTLE, RD, CMP, FIN, TMO.
- RUN:
  - Cycle counter increments every cycle.
  - Done store = (dm_addr==DONE_ADDR && dm_web[0] && dm_di[7:0]==DONE_BYTE).
  - On a done store: latch n = min(num_words, GOLD_DEPTH), go to SETTLE.
  - Else if counter == MAX_CYCLES-1: go to TMO.
  - Done store and timeout in the same cycle: the done store wins.
  - Writes to DONE_ADDR with lane 0 disabled, or a lane-0 byte other than DONE_BYTE, are ignored.
- SETTLE:
  - One cycle so the done write commits.
  - If n==0, go to FIN.
  - Else index i=0, go to RD.
- RD:
  - rd_req=1, rd_addr = ANSWER_START + 4*i (AW-bit wrap), gold_addr = i.
  - Go to CMP.
- CMP:
  - rd_req=0. rd_data and gold_data are valid this cycle.
  - On mismatch: fail_valid=1 for this cycle, fail_idx=i, fail_data=rd_data, fail_expect=gold_data.
  - On mismatch, err_cnt increments unless it is already 255.
  - i++. If i==n go to FIN, else go to RD.
  - Throughput: 2 cycles per word.
- FIN:
  - done=1, pass=(err_cnt==0). Terminal until reset.
  - DM writes are ignored.
- TMO:
  - timeout=1, done=0, pass=0. Terminal until reset.
  - A later done store is ignored.
- fail_data, fail_expect and fail_idx hold their last values between pulses.
- Writes to the DM after the done store are not snooped. The answer region is read as it stands in the RD cycle.

Test Plan:
- All match: n=4, DM[0x9000..0x900c] = {1,2,3,4}, golden = {1,2,3,4}, done store at cycle 100.
  - 4 rd_req at 0x9000, 0x9004, 0x9008, 0x900c.
  - done=1 and pass=1 at cycle 100+1+8+1; err_cnt=0; no fail_valid.
- One mismatch: as above but DM[0x9008] = 0xdeadbeef, golden[2] = 3.
  - One fail_valid pulse with fail_idx=2, fail_data=0xdeadbeef, fail_expect=3.
  - err_cnt=1, done=1, pass=0.
- Near-miss done stores:
  - 0xfe to 0xfffc, or 0xff with dm_web=4'b0010, leave the FSM in RUN.
  - A later dm_web=4'b0001, dm_di=32'h000000ff store to 0xfffc starts the compare.
- Timeout: MAX_CYCLES=50, no done store.
  - timeout=1 at the cycle after counter reaches 49; done=0.
  - A done store at cycle 60 has no effect.
- Edge counts:
  - num_words=0: done=pass=1 two cycles after the done store, no rd_req.
  - num_words=200: exactly 100 comparisons, last rd_addr = 0x918c.
- Reset mid-compare: assert rst in the CMP cycle of word 1.
  - Next cycle all outputs are 0 and the FSM is in RUN.
  - A new done store reruns the walk from i=0.

Source files
------------

// File: rtl/result_checker.sv
// result_checker
//   End-of-test checker beside the CPU data memory. Snoops the DM write port
//   for the done-flag store (DONE_BYTE in lane 0 of DONE_ADDR), then walks the
//   answer region one word every two cycles and compares it against a golden
//   ROM. Flags a timeout if the budget runs out before the done store.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   dm_web/addr/di  snooped DM write port (byte enables, byte address, data)
//   num_words       golden word count, sampled at the done store
//   rd_req/addr     DM read strobe/byte address; rd_data valid one cycle later
//   gold_addr       golden ROM index; gold_data valid one cycle later
//   fail_*          per-mismatch pulse and record (record holds between pulses)
//   err_cnt         saturating mismatch count
//   done/pass       compare finished / finished with no mismatches (sticky)
//   timeout         budget exhausted before the done store (sticky)
module result_checker #(
  parameter int            AW           = 16,
  parameter logic [AW-1:0] ANSWER_START = 16'h9000,
  parameter logic [AW-1:0] DONE_ADDR    = 16'hfffc,
  parameter logic [7:0]    DONE_BYTE    = 8'hff,
  parameter int            GOLD_DEPTH   = 100,
  parameter int            GW           = 7,
  parameter int            MAX_CYCLES   = 50000,
  parameter int            CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    dm_web,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_di,
  input  logic [7:0]    num_words,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic [GW-1:0] gold_addr,
  input  logic [31:0]   gold_data,
  output logic          fail_valid,
  output logic [GW-1:0] fail_idx,
  output logic [31:0]   fail_data,
  output logic [31:0]   fail_expect,
  output logic [7:0]    err_cnt,
  output logic          done,
  output logic          pass,
  output logic          timeout
);

  typedef enum logic [2:0] {RUN, SETTLE, RD, CMP, FIN, TMO} state_t;

  state_t        st;
  logic [CW-1:0] cyc;
  logic [7:0]    n, idx, idx_nxt, n_clamp, err_nxt;
  logic [GW-1:0] fidx_q;
  logic [31:0]   fdata_q, fexp_q;
  logic          done_store, mism;
  logic          unused_ok;

  assign done_store = (dm_addr == DONE_ADDR) && dm_web[0] && (dm_di[7:0] == DONE_BYTE);
  assign n_clamp    = (num_words > 8'(GOLD_DEPTH)) ? 8'(GOLD_DEPTH) : num_words;
  assign idx_nxt    = idx + 8'd1;

  // Read and ROM data both land in CMP, so the mismatch pulse is combinational
  // in that cycle; the record registers only keep the last one for later.
  assign mism        = (st == CMP) && (rd_data != gold_data);
  assign err_nxt     = (mism && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
  assign fail_valid  = mism;
  assign fail_idx    = mism ? idx[GW-1:0] : fidx_q;
  assign fail_data   = mism ? rd_data     : fdata_q;
  assign fail_expect = mism ? gold_data   : fexp_q;

  // Only lane 0 of the flag word matters.
  assign unused_ok = &{1'b0, dm_web[3:1], dm_di[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      cyc       <= '0;
      n         <= '0;
      idx       <= '0;
      err_cnt   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      gold_addr <= '0;
      fidx_q    <= '0;
      fdata_q   <= '0;
      fexp_q    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (st)
        RUN: begin
          cyc <= cyc + 1'b1;
          // done store wins over a same-cycle timeout
          if (done_store) begin
            n  <= n_clamp;
            st <= SETTLE;
          end else if (cyc == CW'(MAX_CYCLES - 1)) begin
            timeout <= 1'b1;
            st      <= TMO;
          end
        end
        SETTLE: begin
          // one idle cycle lets the flag write commit before reads start
          if (n == 8'd0) begin
            done <= 1'b1;
            pass <= (err_cnt == 8'd0);
            st   <= FIN;
          end else begin
            idx       <= '0;
            rd_req    <= 1'b1;
            rd_addr   <= ANSWER_START;
            gold_addr <= '0;
            st        <= RD;
          end
        end
        RD: begin
          rd_req <= 1'b0;
          st     <= CMP;
        end
        CMP: begin
          err_cnt <= err_nxt;
          if (mism) begin
            fidx_q  <= idx[GW-1:0];
            fdata_q <= rd_data;
            fexp_q  <= gold_data;
          end
          idx <= idx_nxt;
          if (idx_nxt == n) begin
            done <= 1'b1;
            pass <= (err_nxt == 8'd0);
            st   <= FIN;
          end else begin
            rd_req    <= 1'b1;
            rd_addr   <= ANSWER_START + AW'({idx_nxt, 2'b00});
            gold_addr <= idx_nxt[GW-1:0];
            st        <= RD;
          end
        end
        FIN, TMO: st <= st;
        default:  st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: DM and golden ROM are modelled as
// arrays with one-cycle read latency; a second instance with a short budget
// covers the timeout path.
module tb_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  dm_web = '0;
  logic [15:0] dm_addr = '0;
  logic [31:0] dm_di = '0;
  logic [7:0]  num_words = 8'd4;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [6:0]  gold_addr;
  logic [31:0] gold_data = '0;
  logic        fail_valid;
  logic [6:0]  fail_idx;
  logic [31:0] fail_data, fail_expect;
  logic [7:0]  err_cnt;
  logic        done, pass, timeout;

  logic        rd_req2, fail_valid2, done2, pass2, timeout2;
  logic [15:0] rd_addr2;
  logic [6:0]  gold_addr2, fail_idx2;
  logic [31:0] fail_data2, fail_expect2;
  logic [7:0]  err_cnt2;

  logic [31:0] dm [0:16383];
  logic [31:0] gold [0:99];

  int npass = 0, ntot = 0;
  int rel, nreq, nfail, done_at;
  int req_cyc [$];
  logic [15:0] q_addr [$];
  logic [31:0] f_idx, f_data, f_exp;

  always #5 clk = ~clk;

  result_checker dut (
    .clk(clk), .rst(rst), .dm_web(dm_web), .dm_addr(dm_addr), .dm_di(dm_di),
    .num_words(num_words), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .gold_addr(gold_addr), .gold_data(gold_data), .fail_valid(fail_valid),
    .fail_idx(fail_idx), .fail_data(fail_data), .fail_expect(fail_expect),
    .err_cnt(err_cnt), .done(done), .pass(pass), .timeout(timeout));

  result_checker #(.MAX_CYCLES(50)) dut2 (
    .clk(clk), .rst(rst), .dm_web(dm_web), .dm_addr(dm_addr), .dm_di(dm_di),
    .num_words(num_words), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_data(32'h0),
    .gold_addr(gold_addr2), .gold_data(32'h0), .fail_valid(fail_valid2),
    .fail_idx(fail_idx2), .fail_data(fail_data2), .fail_expect(fail_expect2),
    .err_cnt(err_cnt2), .done(done2), .pass(pass2), .timeout(timeout2));

  // memory models, one-cycle read latency
  always @(posedge clk) begin
    if (rd_req) rd_data <= dm[rd_addr[15:2]];
    gold_data <= gold[gold_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic stepn(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;   // now in cycle 0 after release
  endtask

  task automatic store(input logic [31:0] di, input logic [3:0] web);
    dm_addr = 16'hfffc; dm_di = di; dm_web = web;
    step();
    dm_addr = '0; dm_di = '0; dm_web = '0;
  endtask

  // Called right after store(): sample each cycle until done or budget.
  task automatic walk(input int budget);
    rel = 1; nreq = 0; nfail = 0; done_at = -1;
    req_cyc.delete(); q_addr.delete();
    while (!done && rel < budget) begin
      if (rd_req) begin nreq++; req_cyc.push_back(rel); q_addr.push_back(rd_addr); end
      if (fail_valid) begin
        nfail++; f_idx = 32'(fail_idx); f_data = fail_data; f_exp = fail_expect;
      end
      step(); rel++;
    end
    if (done) done_at = rel;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) dm[i] = 32'h0;
    for (int k = 0; k < 100; k++) begin
      gold[k] = 32'(k + 1);
      dm[(16'h9000 >> 2) + k] = 32'(k + 1);
    end

    // reset state (checked while reset is held)
    rst = 1'b1; step(); step();
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_gold_addr", 32'(gold_addr), 0);
    chk("rst_fail", {fail_valid, fail_idx, 24'h0} | fail_data | fail_expect, 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_flags", {29'h0, done, pass, timeout}, 0);
    rst = 1'b0;

    // all match, done store at cycle 100
    do_reset(); stepn(100);
    num_words = 8'd4;
    store(32'h000000ff, 4'b0001);
    walk(40);
    chk("am_nreq", nreq, 4);
    chk("am_req0_cyc", req_cyc[0], 2);
    chk("am_req3_cyc", req_cyc[3], 8);
    chk("am_addr0", 32'(q_addr[0]), 32'h9000);
    chk("am_addr1", 32'(q_addr[1]), 32'h9004);
    chk("am_addr2", 32'(q_addr[2]), 32'h9008);
    chk("am_addr3", 32'(q_addr[3]), 32'h900c);
    chk("am_done_at", done_at, 10);
    chk("am_pass", 32'(pass), 1);
    chk("am_err", 32'(err_cnt), 0);
    chk("am_nfail", nfail, 0);

    // one mismatch at word 2
    dm[(16'h9008 >> 2)] = 32'hdeadbeef;
    do_reset(); stepn(5);
    store(32'h000000ff, 4'b0001);
    walk(40);
    chk("mm_nfail", nfail, 1);
    chk("mm_idx", f_idx, 2);
    chk("mm_data", f_data, 32'hdeadbeef);
    chk("mm_exp", f_exp, 3);
    chk("mm_err", 32'(err_cnt), 1);
    chk("mm_done", 32'(done), 1);
    chk("mm_pass", 32'(pass), 0);
    chk("mm_hold_data", fail_data, 32'hdeadbeef);
    chk("mm_hold_idx", 32'(fail_idx), 2);
    dm[(16'h9008 >> 2)] = 32'h3;

    // near-miss done stores
    do_reset(); stepn(3);
    store(32'h000000fe, 4'b0001);
    walk(8);
    chk("nm_fe_nreq", nreq, 0);
    chk("nm_fe_done", 32'(done), 0);
    store(32'h0000ffff, 4'b0010);
    walk(8);
    chk("nm_lane_nreq", nreq, 0);
    chk("nm_lane_done", 32'(done), 0);
    store(32'h000000ff, 4'b0001);
    walk(40);
    chk("nm_ok_done_at", done_at, 10);
    chk("nm_ok_pass", 32'(pass), 1);

    // num_words = 0
    do_reset(); stepn(3);
    num_words = 8'd0;
    store(32'h000000ff, 4'b0001);
    walk(20);
    chk("z_done_at", done_at, 2);
    chk("z_nreq", nreq, 0);
    chk("z_pass", 32'(pass), 1);

    // num_words = 200 clamps to 100
    do_reset(); stepn(3);
    num_words = 8'd200;
    store(32'h000000ff, 4'b0001);
    walk(400);
    chk("big_nreq", nreq, 100);
    chk("big_last_addr", 32'(q_addr[q_addr.size()-1]), 32'h918c);
    chk("big_done_at", done_at, 202);
    chk("big_pass", 32'(pass), 1);

    // reset in the CMP cycle of word 1 (word 1 made to mismatch)
    dm[(16'h9004 >> 2)] = 32'h0badf00d;
    num_words = 8'd4;
    do_reset(); stepn(3);
    store(32'h000000ff, 4'b0001);
    stepn(4);   // relative cycle 5 = CMP of word 1
    chk("mr_in_cmp", 32'(fail_valid), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_rd_req", 32'(rd_req), 0);
    chk("mr_addrs", {16'h0, rd_addr} | 32'(gold_addr), 0);
    chk("mr_fail", {fail_valid, fail_idx, 24'h0} | fail_data | fail_expect, 0);
    chk("mr_err", 32'(err_cnt), 0);
    chk("mr_flags", {29'h0, done, pass, timeout}, 0);
    stepn(2);
    store(32'h000000ff, 4'b0001);
    walk(40);
    chk("mr_re_addr0", 32'(q_addr[0]), 32'h9000);
    chk("mr_re_nreq", nreq, 4);
    chk("mr_re_idx", f_idx, 1);
    chk("mr_re_err", 32'(err_cnt), 1);
    chk("mr_re_done_at", done_at, 10);
    dm[(16'h9004 >> 2)] = 32'h2;

    // timeout on the short-budget instance
    do_reset(); stepn(49);
    chk("to_c49", 32'(timeout2), 0);
    step();
    chk("to_c50", 32'(timeout2), 1);
    chk("to_done", 32'(done2), 0);
    stepn(10);  // cycle 60
    store(32'h000000ff, 4'b0001);
    nreq = 0;
    for (int i = 0; i < 15; i++) begin
      if (rd_req2) nreq++;
      step();
    end
    chk("to_late_nreq", nreq, 0);
    chk("to_late_flags", {29'h0, done2, pass2, timeout2}, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
